// File: rtl/nn_result_fifo_port.sv
`default_nettype none
// ============================================================================
// Module   : nn_result_fifo_port
// Purpose  : Small result FIFO between the MLP argmax stage and an HPS input
//            PIO. The head entry is presented as a registered, glitch-free
//            24-bit status word. The HPS pops an entry by toggling ack_tog.
// Ports    : clk, reset       - clock, asynchronous active-high reset
//            in_valid/in_ready- upstream result handshake (in_ready = !full)
//            in_class/in_score- winning class index and score
//            ack_tog          - pop request, one pop per level change
//            out_word         - {valid, ovf, level[2:0], seq[2:0], class, score}
//            out_irq          - high while the FIFO holds entries (registered)
// Revision : 1.0 - initial release
// ============================================================================
module nn_result_fifo_port #(
   parameter int DEPTH   = 4,
   parameter int CLASS_W = 4,
   parameter int SCORE_W = 12
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [CLASS_W-1:0] in_class,
   input  logic [SCORE_W-1:0] in_score,
   input  logic               ack_tog,
   output logic [23:0]        out_word,
   output logic               out_irq
);

   localparam int                 c_ptr_w      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int                 c_entry_w    = 3 + CLASS_W + SCORE_W;
   localparam logic [c_ptr_w-1:0] c_last_ptr   = c_ptr_w'(DEPTH - 1);
   localparam logic [2:0]         c_full_level = 3'(DEPTH);

   // Entry layout: {seq, class, score}
   logic [c_entry_w-1:0] r_mem [DEPTH];

   logic [c_ptr_w-1:0]   r_wr_ptr;
   logic [c_ptr_w-1:0]   r_rd_ptr;
   logic [2:0]           r_level;
   logic [2:0]           r_seq_cnt;
   logic                 r_ovf;
   logic                 r_ack_q;
   logic [23:0]          r_out_word;
   logic                 r_out_irq;

   logic                 w_full;
   logic                 w_empty;
   logic                 w_pop_req;
   logic                 w_push;
   logic                 w_pop;
   logic [c_entry_w-1:0] w_head;

   assign w_full    = (r_level == c_full_level);
   assign w_empty   = (r_level == 3'd0);
   assign in_ready  = !w_full;
   // Any level change on ack_tog is one pop request.
   assign w_pop_req = ack_tog ^ r_ack_q;
   assign w_push    = in_valid && !w_full;
   // A pop against an empty FIFO is dropped, even if a push lands this cycle.
   assign w_pop     = w_pop_req && !w_empty;
   assign w_head    = r_mem[r_rd_ptr];

   assign out_word  = r_out_word;
   assign out_irq   = r_out_irq;

   // Storage needs no reset: the level register masks stale contents.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {r_seq_cnt, in_class, in_score};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_level   <= 3'd0;
         r_seq_cnt <= 3'd0;
         r_ovf     <= 1'b0;
         r_ack_q   <= 1'b0;
      end else begin
         r_ack_q <= ack_tog;

         if (w_push) begin
            r_wr_ptr  <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
            r_seq_cnt <= r_seq_cnt + 3'd1;
         end

         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
         end

         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 3'd1;
            2'b01:   r_level <= r_level - 3'd1;
            default: r_level <= r_level;
         endcase

         // Sticky overflow: a dropped sample wins over a clearing pop.
         if (in_valid && w_full) begin
            r_ovf <= 1'b1;
         end else if (w_pop) begin
            r_ovf <= 1'b0;
         end
      end
   end

   // Status word is built from the registered FIFO state, so every change
   // shows up one edge after the push/pop that caused it, with no glitches.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_word <= 24'h0;
         r_out_irq  <= 1'b0;
      end else begin
         r_out_word <= {!w_empty, r_ovf, r_level,
                        w_empty ? {c_entry_w{1'b0}} : w_head};
         r_out_irq  <= !w_empty;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_nn_result_fifo_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_nn_result_fifo_port
// Purpose  : Self-checking bench for nn_result_fifo_port. Stimulus records
//            every accepted result in a scoreboard queue; a monitor checks each
//            new head word presented on out_word against the queue front.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nn_result_fifo_port;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  in_class = 4'd0;
   logic [11:0] in_score = 12'd0;
   logic        ack_tog = 1'b0;
   logic [23:0] out_word;
   logic        out_irq;

   int total = 0;
   int bad   = 0;

   // Bench-side reference state
   logic [18:0] sb[$];
   int          m_level = 0;
   logic [2:0]  m_seq   = 3'd0;
   logic        m_ovf   = 1'b0;
   logic        m_ackq  = 1'b0;

   nn_result_fifo_port #(.DEPTH(DEPTH), .CLASS_W(4), .SCORE_W(12)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_class (in_class),
      .in_score (in_score),
      .ack_tog  (ack_tog),
      .out_word (out_word),
      .out_irq  (out_irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every distinct head entry must match the next accepted result.
   logic       mon_have = 1'b0;
   logic [2:0] mon_seq  = 3'd0;
   always @(negedge clk) begin
      if (reset) begin
         mon_have = 1'b0;
      end else if (out_word[23] && (!mon_have || out_word[18:16] != mon_seq)) begin
         mon_have = 1'b1;
         mon_seq  = out_word[18:16];
         if (sb.size() == 0) begin
            check("unexpected_head", {5'd0, out_word[18:0]}, 24'h0);
         end else begin
            check("head_entry", {5'd0, out_word[18:0]}, {5'd0, sb.pop_front()});
         end
      end
   end

   // One clock of stimulus; called at posedge+1.
   task automatic cycle(input logic v, input logic [3:0] c, input logic [11:0] s, input logic pop);
      logic p, pe, pu;
      in_valid = v;
      in_class = c;
      in_score = s;
      if (pop) ack_tog = ~ack_tog;
      p  = ack_tog ^ m_ackq;
      pe = p && (m_level != 0);
      pu = v && (m_level < DEPTH);
      if (pu) begin
         sb.push_back({m_seq, c, s});
         m_seq = m_seq + 3'd1;
      end
      if (v && !pu)  m_ovf = 1'b1;
      else if (pe)   m_ovf = 1'b0;
      m_level = m_level + int'(pu) - int'(pe);
      m_ackq  = ack_tog;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 12'd0, 1'b0);
   endtask

   task automatic status(input string name);
      idle(2);
      check({name, "_flags"}, {19'd0, out_word[23:19]},
            {19'd0, (m_level != 0), m_ovf, 3'(m_level)});
      check({name, "_irq"}, {23'd0, out_irq}, {23'd0, (m_level != 0)});
      check({name, "_ready"}, {23'd0, in_ready}, {23'd0, (m_level < DEPTH)});
   endtask

   task automatic drain();
      for (int k = 0; k < 8 && m_level > 0; k++) cycle(1'b0, 4'd0, 12'd0, 1'b1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      sb.delete();
      m_level = 0;
      m_seq   = 3'd0;
      m_ovf   = 1'b0;
      m_ackq  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // Test 1: reset state and first push latency
      repeat (2) @(posedge clk);
      #1;
      do_reset();
      check("reset_word", out_word, 24'h0);
      check("reset_irq", {23'd0, out_irq}, 24'h0);
      check("reset_ready", {23'd0, in_ready}, 24'h1);
      cycle(1'b1, 4'd3, 12'h1A5, 1'b0);
      check("t1_latency", out_word, 24'h0);
      idle(1);
      check("t1_word", out_word, 24'h8831A5);
      check("t1_irq", {23'd0, out_irq}, 24'h1);
      drain();
      status("t1_drained");
      check("t1_empty_word", out_word, 24'h0);

      // Test 2: fill, overflow, pop clears ovf
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1'b1, 4'(i + 1), 12'(12'h010 * (i + 1)), 1'b0);
      cycle(1'b1, 4'hF, 12'hFFF, 1'b0);
      cycle(1'b1, 4'hE, 12'hEEE, 1'b0);
      status("t2_full");
      check("t2_ovf_word", {16'd0, out_word[23:16]}, 24'hE0);
      cycle(1'b0, 4'd0, 12'd0, 1'b1);
      status("t2_pop");
      check("t2_pop_word", {16'd0, out_word[23:16]}, 24'h99);
      cycle(1'b1, 4'd7, 12'h777, 1'b0);
      drain();
      status("t2_drained");

      // Test 3: pops on an empty FIFO are ignored
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 4'd0, 12'd0, 1'b1);
         check("t3_empty_word", out_word, 24'h0);
         check("t3_empty_ready", {23'd0, in_ready}, 24'h1);
      end
      cycle(1'b1, 4'd5, 12'h055, 1'b0);
      idle(1);
      check("t3_word", out_word, 24'h8D5055);

      // Test 4: simultaneous push and pop at level 2
      cycle(1'b1, 4'd6, 12'h066, 1'b0);
      status("t4_level2");
      cycle(1'b1, 4'd7, 12'h077, 1'b1);
      status("t4_pushpop");
      check("t4_word", {16'd0, out_word[23:16]}, 24'h96);
      drain();
      status("t4_drained");

      // Test 5: interleaved pushes/pops across seq and pointer wrap
      for (int i = 0; i < 10; i++)
         cycle(1'b1, 4'(i), 12'(12'h300 + i), (i % 2 == 1) || (i >= 6));
      drain();
      status("t5_drained");

      // Test 6: asynchronous reset mid-stream, spurious pop on release
      for (int i = 0; i < 3; i++) cycle(1'b1, 4'(i + 10), 12'(12'h0A0 + i), 1'b0);
      status("t6_level3");
      #2;
      reset   = 1'b1;
      ack_tog = 1'b1;
      #1;
      check("t6_async_word", out_word, 24'h0);
      check("t6_async_irq", {23'd0, out_irq}, 24'h0);
      sb.delete();
      m_level = 0;
      m_seq   = 3'd0;
      m_ovf   = 1'b0;
      m_ackq  = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      cycle(1'b1, 4'd9, 12'h0C3, 1'b0);
      idle(1);
      check("t6_first_push", out_word, 24'h8890C3);
      drain();
      status("t6_drained");

      check("sb_empty", 24'(sb.size()), 24'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
